// File: rtl/regfile_sched_pkg.sv
// ---------------------------------------------------------------------------
// regfile_sched_pkg
//
// Purpose:
//   Shared definitions for the register file scheduler: the scheduler state
//   encoding, the register file clock-enable phase codes, default widths,
//   and a helper that maps a scheduler state to its register file phase.
//
// Contents:
//   DATA_W_DEF / ADDR_W_DEF : default register width / address width
//   PH_HOLD / PH_READ / PH_WRITE : RF_CLK_EN phase codes
//   state_t                 : scheduler FSM states
//   phaseOf()               : state -> RF_CLK_EN phase
// ---------------------------------------------------------------------------
package regfile_sched_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [1:0] PH_HOLD  = 2'b00;
  localparam logic [1:0] PH_READ  = 2'b01;
  localparam logic [1:0] PH_WRITE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_EXEC     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DBG_RD   = 3'd4,
    ST_DBG_WAIT = 3'd5,
    ST_DBG_WR   = 3'd6
  } state_t;

  // Read phases clock the register file's read registers, write phases
  // clock its write port; every other state leaves the register file idle.
  function automatic logic [1:0] phaseOf(input state_t st);
    logic [1:0] ph;
    ph = PH_HOLD;
    case (st)
      ST_READ, ST_DBG_RD:  ph = PH_READ;
      ST_WRITE, ST_DBG_WR: ph = PH_WRITE;
      default:             ph = PH_HOLD;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/register_file_scheduler.sv
// ---------------------------------------------------------------------------
// register_file_scheduler
//
// Purpose:
//   Sequences a two-port register file through read / write clock-enable
//   phases and shares it between the core datapath and a debug port. Each
//   core instruction runs READ -> EXEC (stallable) -> WRITE. Debug reads and
//   writes are slotted in only at instruction boundaries (IDLE or WRITE),
//   alternating fairly with core instructions while the core is running.
//
// Ports:
//   CLK, RESET             : clock (rising edge), synchronous active-high reset
//   CORE_RUN, CORE_STALL   : core issue request, EXEC hold
//   CORE_RD_ADDR1/2        : core read addresses
//   CORE_WR_ADDR, CORE_WE, CORE_WDATA : core writeback
//   DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA : debug request (held until ack)
//   DBG_ACK, DBG_RDATA     : one-cycle completion pulse, last debug read value
//   RF_CLK_EN              : 01 read, 10 write, 00 hold
//   RF_READ_ADDRESS1/2, RF_WRITE_ADDRESS, RF_WRITE_ENABLE, RF_WRITE_DATA
//   RF_READ_DATA1          : register file port-1 registered read data
//   INSTR_DONE             : high in every core WRITE cycle
// ---------------------------------------------------------------------------
module register_file_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CORE_RUN,
  input  logic              CORE_STALL,
  input  logic [ADDR_W-1:0] CORE_RD_ADDR1,
  input  logic [ADDR_W-1:0] CORE_RD_ADDR2,
  input  logic [ADDR_W-1:0] CORE_WR_ADDR,
  input  logic              CORE_WE,
  input  logic [DATA_W-1:0] CORE_WDATA,
  input  logic              DBG_REQ,
  input  logic              DBG_WE,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  output logic              DBG_ACK,
  output logic [DATA_W-1:0] DBG_RDATA,
  output logic [1:0]        RF_CLK_EN,
  output logic [ADDR_W-1:0] RF_READ_ADDRESS1,
  output logic [ADDR_W-1:0] RF_READ_ADDRESS2,
  output logic [ADDR_W-1:0] RF_WRITE_ADDRESS,
  output logic              RF_WRITE_ENABLE,
  output logic [DATA_W-1:0] RF_WRITE_DATA,
  input  logic [DATA_W-1:0] RF_READ_DATA1,
  output logic              INSTR_DONE
);

  state_t              r_state;
  state_t              w_nextState;
  logic                r_dbgServed;
  logic                r_dbgWe;
  logic [ADDR_W-1:0]   r_dbgAddr;
  logic [DATA_W-1:0]   r_dbgWdata;
  logic [DATA_W-1:0]   r_dbgRdata;
  logic                r_dbgAck;
  logic [ADDR_W-1:0]   r_rdAddr1;
  logic [ADDR_W-1:0]   r_rdAddr2;
  logic                w_boundary;
  logic                w_dbgAccept;
  logic                w_wrReq;
  logic [ADDR_W-1:0]   w_wrAddr;
  logic [DATA_W-1:0]   w_wrData;

  // A debug op may start only at an instruction boundary. The request is
  // ignored in the cycle it is being acked (the requester has not dropped
  // it yet), and a second debug op in a row is refused while the core
  // wants to run, so the core gets one instruction between debug ops.
  assign w_boundary  = (r_state == ST_IDLE) || (r_state == ST_WRITE);
  assign w_dbgAccept = w_boundary && DBG_REQ && !r_dbgAck &&
                       (!r_dbgServed || !CORE_RUN);

  // Next-state selection. EXEC is the only state that honours the stall;
  // after any debug op the core is resumed directly if it wants to run.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_WRITE: begin
        if (w_dbgAccept) begin
          w_nextState = DBG_WE ? ST_DBG_WR : ST_DBG_RD;
        end else if (CORE_RUN) begin
          w_nextState = ST_READ;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_READ:     w_nextState = ST_EXEC;
      ST_EXEC:     w_nextState = CORE_STALL ? ST_EXEC : ST_WRITE;
      ST_DBG_RD:   w_nextState = ST_DBG_WAIT;
      ST_DBG_WAIT: w_nextState = CORE_RUN ? ST_READ : ST_IDLE;
      ST_DBG_WR:   w_nextState = CORE_RUN ? ST_READ : ST_IDLE;
      default:     w_nextState = ST_IDLE;
    endcase
  end

  // State, debug latch and read-address registers. Read addresses are
  // loaded on entry to a read phase and then held, so the register file's
  // registered read data stays stable through EXEC and WRITE. The served
  // flag is raised when a debug op is accepted and cleared once a core
  // instruction starts. A reset drops any in-flight debug op without ack.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_dbgServed <= 1'b0;
      r_dbgWe     <= 1'b0;
      r_dbgAddr   <= '0;
      r_dbgWdata  <= '0;
      r_dbgRdata  <= '0;
      r_dbgAck    <= 1'b0;
      r_rdAddr1   <= '0;
      r_rdAddr2   <= '0;
    end else begin
      r_state  <= w_nextState;
      r_dbgAck <= (r_state == ST_DBG_WAIT) || (r_state == ST_DBG_WR);
      if (r_state == ST_DBG_WAIT) begin
        r_dbgRdata <= RF_READ_DATA1;
      end
      if (w_dbgAccept) begin
        r_dbgServed <= 1'b1;
        r_dbgWe     <= DBG_WE;
        r_dbgAddr   <= DBG_ADDR;
        r_dbgWdata  <= DBG_WDATA;
        r_rdAddr1   <= DBG_ADDR;
      end else if (w_nextState == ST_READ) begin
        r_dbgServed <= 1'b0;
        r_rdAddr1   <= CORE_RD_ADDR1;
        r_rdAddr2   <= CORE_RD_ADDR2;
      end
    end
  end

  // Write-port source: the core in WRITE, the latched debug request in
  // DBG_WR. Outside write phases the port presents zeros.
  always_comb begin
    w_wrReq  = 1'b0;
    w_wrAddr = '0;
    w_wrData = '0;
    case (r_state)
      ST_WRITE: begin
        w_wrReq  = CORE_WE;
        w_wrAddr = CORE_WR_ADDR;
        w_wrData = CORE_WDATA;
      end
      ST_DBG_WR: begin
        w_wrReq  = r_dbgWe;
        w_wrAddr = r_dbgAddr;
        w_wrData = r_dbgWdata;
      end
      default: begin
        w_wrReq  = 1'b0;
        w_wrAddr = '0;
        w_wrData = '0;
      end
    endcase
  end

  // Register x0 is never written. Reset gates the phase and write enable
  // combinationally so nothing reaches the register file during reset,
  // whatever state the FSM happens to be in.
  assign RF_CLK_EN        = RESET ? PH_HOLD : phaseOf(r_state);
  assign RF_WRITE_ENABLE  = w_wrReq && (w_wrAddr != '0) && !RESET;
  assign RF_WRITE_ADDRESS = w_wrAddr;
  assign RF_WRITE_DATA    = w_wrData;
  assign RF_READ_ADDRESS1 = r_rdAddr1;
  assign RF_READ_ADDRESS2 = r_rdAddr2;
  assign INSTR_DONE       = (r_state == ST_WRITE);
  assign DBG_ACK          = r_dbgAck;
  assign DBG_RDATA        = r_dbgRdata;

endmodule

// File: tb/tb_register_file_scheduler.sv
// ---------------------------------------------------------------------------
// tb_register_file_scheduler
//
// Self-checking bench for register_file_scheduler. A small behavioural
// register file sits beside the scheduler so that writes and reads can be
// observed end to end. Inputs are driven on the falling edge and outputs
// are sampled on the falling edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_register_file_scheduler;
  import regfile_sched_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CORE_RUN;
  logic        CORE_STALL;
  logic [4:0]  CORE_RD_ADDR1;
  logic [4:0]  CORE_RD_ADDR2;
  logic [4:0]  CORE_WR_ADDR;
  logic        CORE_WE;
  logic [31:0] CORE_WDATA;
  logic        DBG_REQ;
  logic        DBG_WE;
  logic [4:0]  DBG_ADDR;
  logic [31:0] DBG_WDATA;
  logic        DBG_ACK;
  logic [31:0] DBG_RDATA;
  logic [1:0]  RF_CLK_EN;
  logic [4:0]  RF_READ_ADDRESS1;
  logic [4:0]  RF_READ_ADDRESS2;
  logic [4:0]  RF_WRITE_ADDRESS;
  logic        RF_WRITE_ENABLE;
  logic [31:0] RF_WRITE_DATA;
  logic [31:0] RF_READ_DATA1;
  logic        INSTR_DONE;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          lat;
    logic        isRead;
    logic [31:0] data;
    logic        expWe;
  } dbgExp_t;

  dbgExp_t    dbgQ[$];
  logic [1:0] phaseQ[$];

  logic [31:0] rfMem [32];
  logic [31:0] rfRd1;
  logic [31:0] rfRd2;

  register_file_scheduler dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .CORE_RUN         (CORE_RUN),
    .CORE_STALL       (CORE_STALL),
    .CORE_RD_ADDR1    (CORE_RD_ADDR1),
    .CORE_RD_ADDR2    (CORE_RD_ADDR2),
    .CORE_WR_ADDR     (CORE_WR_ADDR),
    .CORE_WE          (CORE_WE),
    .CORE_WDATA       (CORE_WDATA),
    .DBG_REQ          (DBG_REQ),
    .DBG_WE           (DBG_WE),
    .DBG_ADDR         (DBG_ADDR),
    .DBG_WDATA        (DBG_WDATA),
    .DBG_ACK          (DBG_ACK),
    .DBG_RDATA        (DBG_RDATA),
    .RF_CLK_EN        (RF_CLK_EN),
    .RF_READ_ADDRESS1 (RF_READ_ADDRESS1),
    .RF_READ_ADDRESS2 (RF_READ_ADDRESS2),
    .RF_WRITE_ADDRESS (RF_WRITE_ADDRESS),
    .RF_WRITE_ENABLE  (RF_WRITE_ENABLE),
    .RF_WRITE_DATA    (RF_WRITE_DATA),
    .RF_READ_DATA1    (RF_READ_DATA1),
    .INSTR_DONE       (INSTR_DONE)
  );

  always #5 CLK = ~CLK;

  // Behavioural register file: registered reads on the read phase, writes
  // on the write phase when enabled. Cleared whenever reset is high.
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) rfMem[i] <= '0;
      rfRd1 <= '0;
      rfRd2 <= '0;
    end else begin
      if (RF_CLK_EN == PH_READ) begin
        rfRd1 <= rfMem[RF_READ_ADDRESS1];
        rfRd2 <= rfMem[RF_READ_ADDRESS2];
      end
      if (RF_CLK_EN == PH_WRITE && RF_WRITE_ENABLE) begin
        rfMem[RF_WRITE_ADDRESS] <= RF_WRITE_DATA;
      end
    end
  end

  assign RF_READ_DATA1 = rfRd1;

  // Reset state and combinational gating while reset is held.
  task automatic test_reset();
    RESET = 1'b1;
    CORE_RUN = 0; CORE_STALL = 0; CORE_RD_ADDR1 = 0; CORE_RD_ADDR2 = 0;
    CORE_WR_ADDR = 0; CORE_WE = 0; CORE_WDATA = 0;
    DBG_REQ = 0; DBG_WE = 0; DBG_ADDR = 0; DBG_WDATA = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if (RF_CLK_EN !== PH_HOLD || RF_WRITE_ENABLE !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_gating: clk_en=%b we=%b, want 00/0", RF_CLK_EN, RF_WRITE_ENABLE);
    end
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (DBG_ACK !== 1'b0 || DBG_RDATA !== 32'h0 || INSTR_DONE !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: ack=%b rdata=%h done=%b, want 0/0/0", DBG_ACK, DBG_RDATA, INSTR_DONE);
    end
    checks++;
    if (RF_READ_ADDRESS1 !== 5'd0 || RF_READ_ADDRESS2 !== 5'd0 || RF_WRITE_ADDRESS !== 5'd0) begin
      fails++;
      $display("[TB] FAIL reset_addr: ra1=%0d ra2=%0d wa=%0d, want 0", RF_READ_ADDRESS1, RF_READ_ADDRESS2, RF_WRITE_ADDRESS);
    end
    checks++;
    if (RF_CLK_EN !== PH_HOLD) begin
      fails++;
      $display("[TB] FAIL reset_idle_phase: clk_en=%b, want 00", RF_CLK_EN);
    end
  endtask

  // Three back-to-back core instructions writing 0x1234 to r5.
  task automatic test_core_run();
    logic [1:0] exp;
    CORE_RUN = 1; CORE_RD_ADDR1 = 5; CORE_RD_ADDR2 = 6;
    CORE_WR_ADDR = 5; CORE_WE = 1; CORE_WDATA = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      phaseQ.push_back(PH_READ);
      phaseQ.push_back(PH_HOLD);
      phaseQ.push_back(PH_WRITE);
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      exp = phaseQ.pop_front();
      checks++;
      if (RF_CLK_EN !== exp) begin
        fails++;
        $display("[TB] FAIL core_phase[%0d]: got %b want %b", c, RF_CLK_EN, exp);
      end
      checks++;
      if (INSTR_DONE !== (exp == PH_WRITE)) begin
        fails++;
        $display("[TB] FAIL core_done[%0d]: got %b want %b", c, INSTR_DONE, (exp == PH_WRITE));
      end
      if (exp == PH_READ) begin
        checks++;
        if (RF_READ_ADDRESS1 !== 5'd5 || RF_READ_ADDRESS2 !== 5'd6) begin
          fails++;
          $display("[TB] FAIL core_rdaddr[%0d]: got %0d/%0d want 5/6", c, RF_READ_ADDRESS1, RF_READ_ADDRESS2);
        end
      end
      if (exp == PH_WRITE) begin
        checks++;
        if (RF_WRITE_ENABLE !== 1'b1 || RF_WRITE_ADDRESS !== 5'd5 || RF_WRITE_DATA !== 32'h1234) begin
          fails++;
          $display("[TB] FAIL core_wrport[%0d]: we=%b wa=%0d wd=%h want 1/5/1234", c, RF_WRITE_ENABLE, RF_WRITE_ADDRESS, RF_WRITE_DATA);
        end
      end
      if (c == 8) CORE_RUN = 0;
    end
    @(negedge CLK);
    checks++;
    if (RF_CLK_EN !== PH_HOLD || rfMem[5] !== 32'h1234) begin
      fails++;
      $display("[TB] FAIL core_result: clk_en=%b r5=%h want 00/1234", RF_CLK_EN, rfMem[5]);
    end
  endtask

  // Four stalled EXEC edges stretch EXEC to five cycles; r5 read stays put.
  task automatic test_stall();
    logic [1:0] exp;
    CORE_RUN = 1; CORE_RD_ADDR1 = 5; CORE_WR_ADDR = 7; CORE_WE = 1; CORE_WDATA = 32'h55AA;
    phaseQ.push_back(PH_READ);
    repeat (5) phaseQ.push_back(PH_HOLD);
    phaseQ.push_back(PH_WRITE);
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      exp = phaseQ.pop_front();
      checks++;
      if (RF_CLK_EN !== exp) begin
        fails++;
        $display("[TB] FAIL stall_phase[%0d]: got %b want %b", c, RF_CLK_EN, exp);
      end
      if (c == 0) CORE_STALL = 1;
      else if (c <= 5) CORE_STALL = (c <= 4);
      if (c == 6) begin
        checks++;
        if (RF_READ_ADDRESS1 !== 5'd5 || rfRd1 !== 32'h1234 || INSTR_DONE !== 1'b1) begin
          fails++;
          $display("[TB] FAIL stall_hold: ra1=%0d rd1=%h done=%b want 5/1234/1", RF_READ_ADDRESS1, rfRd1, INSTR_DONE);
        end
        CORE_RUN = 0;
      end
    end
    CORE_STALL = 0;
    @(negedge CLK);
    checks++;
    if (rfMem[7] !== 32'h55AA || rfMem[5] !== 32'h1234) begin
      fails++;
      $display("[TB] FAIL stall_result: r7=%h r5=%h want 55aa/1234", rfMem[7], rfMem[5]);
    end
  endtask

  // Debug ops with the core idle, including x0 write protection.
  task automatic test_debug_idle();
    logic        opWe   [4];
    logic [4:0]  opAddr [4];
    logic [31:0] opData [4];
    logic [31:0] expRd  [4];
    dbgExp_t     e;
    int          lat;
    logic        got;
    logic        sawWe;
    opWe[0] = 1; opAddr[0] = 3; opData[0] = 32'hDEADBEEF; expRd[0] = 32'h0;
    opWe[1] = 0; opAddr[1] = 3; opData[1] = 32'h0;        expRd[1] = 32'hDEADBEEF;
    opWe[2] = 1; opAddr[2] = 0; opData[2] = 32'hCAFEF00D; expRd[2] = 32'h0;
    opWe[3] = 0; opAddr[3] = 0; opData[3] = 32'h0;        expRd[3] = 32'h0;
    CORE_RUN = 0;
    for (int op = 0; op < 4; op++) begin
      DBG_REQ = 1; DBG_WE = opWe[op]; DBG_ADDR = opAddr[op]; DBG_WDATA = opData[op];
      dbgQ.push_back('{lat: (opWe[op] ? 2 : 3), isRead: !opWe[op], data: expRd[op],
                       expWe: (opWe[op] && opAddr[op] != 5'd0)});
      lat = 0; got = 0; sawWe = 0;
      while (!got && lat < 12) begin
        @(negedge CLK);
        lat++;
        if (RF_WRITE_ENABLE === 1'b1) sawWe = 1;
        if (DBG_ACK === 1'b1) got = 1;
      end
      DBG_REQ = 0;
      e = dbgQ.pop_front();
      checks++;
      if (!got) begin
        fails++;
        $display("[TB] FAIL dbg_ack_timeout[%0d]: no ack after %0d cycles, want ack at %0d", op, lat, e.lat);
      end else if (lat !== e.lat) begin
        fails++;
        $display("[TB] FAIL dbg_latency[%0d]: ack at T+%0d want T+%0d", op, lat, e.lat);
      end
      if (got && e.isRead) begin
        checks++;
        if (DBG_RDATA !== e.data) begin
          fails++;
          $display("[TB] FAIL dbg_rdata[%0d]: got %h want %h", op, DBG_RDATA, e.data);
        end
      end
      if (got && !e.isRead) begin
        checks++;
        if (sawWe !== e.expWe) begin
          fails++;
          $display("[TB] FAIL dbg_we[%0d]: saw %b want %b", op, sawWe, e.expWe);
        end
      end
      @(negedge CLK);
    end
  endtask

  // Core writeback to x0 must never assert the write enable.
  task automatic test_core_r0();
    logic [1:0] exp;
    CORE_RUN = 1; CORE_RD_ADDR1 = 3; CORE_RD_ADDR2 = 0;
    CORE_WR_ADDR = 0; CORE_WE = 1; CORE_WDATA = 32'h99;
    phaseQ.push_back(PH_READ);
    phaseQ.push_back(PH_HOLD);
    phaseQ.push_back(PH_WRITE);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      exp = phaseQ.pop_front();
      checks++;
      if (RF_CLK_EN !== exp || RF_WRITE_ENABLE !== 1'b0) begin
        fails++;
        $display("[TB] FAIL core_r0[%0d]: clk_en=%b we=%b want %b/0", c, RF_CLK_EN, RF_WRITE_ENABLE, exp);
      end
      if (c == 2) CORE_RUN = 0;
    end
    @(negedge CLK);
    checks++;
    if (rfMem[0] !== 32'h0) begin
      fails++;
      $display("[TB] FAIL core_r0_mem: r0=%h want 0", rfMem[0]);
    end
  endtask

  // DBG_REQ held high with the core running: strict alternation.
  task automatic test_fairness();
    int acks  = 0;
    int dones = 0;
    CORE_RUN = 1; CORE_RD_ADDR1 = 5; CORE_WR_ADDR = 5; CORE_WE = 1; CORE_WDATA = 32'h1234;
    DBG_REQ = 1; DBG_WE = 0; DBG_ADDR = 3;
    for (int c = 0; c < 42; c++) begin
      @(negedge CLK);
      if (INSTR_DONE === 1'b1) dones++;
      if (DBG_ACK === 1'b1) begin
        if (acks > 0) begin
          checks++;
          if (dones !== 1) begin
            fails++;
            $display("[TB] FAIL fair_alternate[%0d]: %0d instr between acks, want 1", acks, dones);
          end
        end
        checks++;
        if (DBG_RDATA !== 32'hDEADBEEF) begin
          fails++;
          $display("[TB] FAIL fair_rdata[%0d]: got %h want deadbeef", acks, DBG_RDATA);
        end
        acks++;
        dones = 0;
      end
    end
    CORE_RUN = 0; DBG_REQ = 0;
    repeat (8) @(negedge CLK);
    checks++;
    if (acks < 4) begin
      fails++;
      $display("[TB] FAIL fair_ack_count: got %0d acks want at least 4", acks);
    end
    checks++;
    if (RF_CLK_EN !== PH_HOLD) begin
      fails++;
      $display("[TB] FAIL fair_drain: clk_en=%b want 00", RF_CLK_EN);
    end
  endtask

  // Reset during DBG_WAIT drops the op; reset during WRITE gates the port.
  task automatic test_reset_mid_op();
    logic sawAck;
    CORE_RUN = 0; DBG_REQ = 1; DBG_WE = 0; DBG_ADDR = 3;
    @(negedge CLK);
    checks++;
    if (RF_CLK_EN !== PH_READ) begin
      fails++;
      $display("[TB] FAIL rst_dbg_rd: clk_en=%b want 01", RF_CLK_EN);
    end
    @(negedge CLK);
    RESET = 1; DBG_REQ = 0;
    #1;
    checks++;
    if (RF_CLK_EN !== PH_HOLD || RF_WRITE_ENABLE !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_dbg_gate: clk_en=%b we=%b want 00/0", RF_CLK_EN, RF_WRITE_ENABLE);
    end
    @(negedge CLK);
    RESET = 0;
    sawAck = DBG_ACK;
    checks++;
    if (DBG_RDATA !== 32'h0) begin
      fails++;
      $display("[TB] FAIL rst_dbg_rdata: got %h want 0", DBG_RDATA);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (DBG_ACK !== 1'b0) sawAck = 1;
    end
    checks++;
    if (sawAck !== 1'b0 || RF_CLK_EN !== PH_HOLD) begin
      fails++;
      $display("[TB] FAIL rst_dbg_noack: ack_seen=%b clk_en=%b want 0/00", sawAck, RF_CLK_EN);
    end
    CORE_RUN = 1; CORE_WR_ADDR = 5; CORE_WE = 1; CORE_WDATA = 32'h7777;
    repeat (3) @(negedge CLK);
    checks++;
    if (INSTR_DONE !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rst_core_write_reached: done=%b want 1", INSTR_DONE);
    end
    RESET = 1; CORE_RUN = 0;
    #1;
    checks++;
    if (RF_CLK_EN !== PH_HOLD || RF_WRITE_ENABLE !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_write_gate: clk_en=%b we=%b want 00/0", RF_CLK_EN, RF_WRITE_ENABLE);
    end
    @(negedge CLK);
    RESET = 0;
    checks++;
    if (INSTR_DONE !== 1'b0 || RF_CLK_EN !== PH_HOLD) begin
      fails++;
      $display("[TB] FAIL rst_write_idle: done=%b clk_en=%b want 0/00", INSTR_DONE, RF_CLK_EN);
    end
    @(negedge CLK);
    checks++;
    if (RF_CLK_EN !== PH_HOLD || DBG_ACK !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_after_idle: clk_en=%b ack=%b want 00/0", RF_CLK_EN, DBG_ACK);
    end
  endtask

  initial begin
    test_reset();
    test_core_run();
    test_stall();
    test_debug_idle();
    test_core_r0();
    test_fairness();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Guards against a hang anywhere in the sequence above.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/register_file_scheduler.md
# register_file_scheduler

Sequences the two-port register file through its read/write clock-enable phases and shares it between the core datapath and a debug port. It drives the register file's CLK_EN, address, write-enable and write-data inputs. Each core instruction gets a fixed READ → EXEC → WRITE phase cycle. Debug reads and writes are inserted only at instruction boundaries, using a req/ack handshake.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- CORE_RUN  in  1  core wants to issue instructions
- CORE_STALL  in  1  holds the EXEC phase (memory wait)
- CORE_RD_ADDR1, CORE_RD_ADDR2  in  ADDR_W  core read addresses
- CORE_WR_ADDR  in  ADDR_W  core writeback address
- CORE_WE  in  1  core writeback enable
- CORE_WDATA  in  DATA_W  core writeback data
- DBG_REQ  in  1  debug request, held until DBG_ACK
- DBG_WE  in  1  1 = write, 0 = read
- DBG_ADDR  in  ADDR_W  debug register address
- DBG_WDATA  in  DATA_W  debug write data
- DBG_ACK  out  1  one-cycle completion pulse
- DBG_RDATA  out  DATA_W  debug read result, held until the next debug read
- RF_CLK_EN  out  2  phase to register file: 01 read, 10 write, 00 hold
- RF_READ_ADDRESS1, RF_READ_ADDRESS2  out  ADDR_W
- RF_WRITE_ADDRESS  out  ADDR_W
- RF_WRITE_ENABLE  out  1
- RF_WRITE_DATA  out  DATA_W
- RF_READ_DATA1  in  DATA_W  register file port-1 output
- INSTR_DONE  out  1  pulses in each core WRITE cycle

## Operation
States and RF_CLK_EN: IDLE(00), READ(01), EXEC(00), WRITE(10), DBG_RD(01), DBG_WAIT(00), DBG_WR(10).

Boundary cycle = IDLE or WRITE. At a boundary, the next state is chosen as:
- DBG_REQ=1 and no debug op was served at the previous boundary → DBG_RD (DBG_WE=0) or DBG_WR (DBG_WE=1). DBG_WE, DBG_ADDR and DBG_WDATA are latched at this edge.
- else CORE_RUN=1 → READ.
- else → IDLE.

Fairness: after a debug op completes, one core instruction runs before the next debug op, provided CORE_RUN=1. If CORE_RUN=0, back-to-back debug ops are allowed.

Core phases:
- READ → EXEC.
- EXEC → stays in EXEC while CORE_STALL=1, else → WRITE.
- CORE_STALL is ignored in every other state.

Debug phases:
- DBG_RD → DBG_WAIT.
- DBG_WAIT: RF_READ_DATA1 is captured into DBG_RDATA; then go to IDLE, or to READ if CORE_RUN=1.
- DBG_WR → IDLE, or → READ if CORE_RUN=1.

Address and data muxing:
- Read addresses come from the core in READ/EXEC/WRITE and from the latched DBG_ADDR (port 1) in DBG_RD/DBG_WAIT.
- Read addresses are held constant from the read phase through the write phase, so the register file's registered read data stays stable.
- RF_WRITE_ENABLE = CORE_WE in WRITE, 1 in DBG_WR, else 0. It is forced to 0 when the write address is 0 (x0 is never written); DBG_ACK is still issued.

DBG_ACK is registered and asserted the cycle after DBG_WAIT or DBG_WR. Once acked, DBG_REQ is not re-sampled until the next boundary.

RESET:
- While RESET=1, RF_CLK_EN=00 and RF_WRITE_ENABLE=0 (combinational gating).
- State goes to IDLE at the next edge. An in-flight debug op is dropped with no ack.
- Reset values: DBG_ACK=0, DBG_RDATA=0, INSTR_DONE=0, all address outputs 0.

## Timing
- Core instruction: 3 cycles, plus one per stalled EXEC cycle. Back-to-back instructions give RF_CLK_EN 01,00,10,01,...
- Debug read accepted at boundary cycle T: DBG_RD at T+1, DBG_WAIT at T+2, DBG_ACK=1 with DBG_RDATA valid at T+3.
- Debug write accepted at T: write edge at end of T+1, DBG_ACK at T+2.
- INSTR_DONE is combinational from the WRITE state.
- DBG_REQ arriving mid-instruction waits for WRITE, adding at most 3 + stall cycles.

## Structure
- Shared package regfile_sched_pkg holds:
  - state encoding
  - phase constants PH_HOLD=2'b00, PH_READ=2'b01, PH_WRITE=2'b10
  - DATA_W/ADDR_W defaults
- Single flat module, no sub-module. It is instantiated beside register_file, with RF_* wired to that module's ports.

## Test plan
- Reset, then CORE_RUN=1 with no stalls → RF_CLK_EN sequence 00,01,00,10,01,...; INSTR_DONE every third cycle; write of 0x1234 to r5 lands.
- CORE_STALL=1 for 4 cycles in EXEC → RF_CLK_EN=00 for 5 cycles; WRITE follows; data unchanged.
- CORE_RUN=0, debug write r3←0xDEADBEEF then debug read r3 → ACK at T+2 for the write; ACK at T+3 for the read with DBG_RDATA=0xDEADBEEF.
- CORE_RUN=1 with DBG_REQ held high continuously → core and debug ops alternate; exactly one INSTR_DONE between consecutive DBG_ACKs.
- Debug write to r0 and core write to r0 → RF_WRITE_ENABLE stays 0; debug read of r0 returns 0; ACK still issued.
- RESET asserted during DBG_WAIT → no DBG_ACK; DBG_RDATA=0; RF_CLK_EN=00 in the reset cycle; IDLE afterwards.
